// File: rtl/jpeg_sched_pkg.sv
// Shared definitions for the JPEG MCU scheduler: FSM states, component
// codes, block size and the per-subsampling slot tables.
package jpeg_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        STREAM,
        RESTART,
        DONE
    } sched_state_t;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int unsigned BEATS_PER_BLOCK = 64;

    localparam int unsigned SLOTS_420_LEN = 6;
    localparam int unsigned SLOTS_444_LEN = 3;

    // Entry [0] is the first slot of an MCU.
    localparam logic [5:0][1:0] SLOTS_420 = {COMP_CR, COMP_CB, COMP_Y, COMP_Y, COMP_Y, COMP_Y};
    localparam logic [2:0][1:0] SLOTS_444 = {COMP_CR, COMP_CB, COMP_Y};

    // Component served by a slot of the MCU walk.
    function automatic logic [1:0] slot_comp(input logic is_420, input logic [2:0] slot);
        logic [1:0] c;
        c = COMP_Y;
        if (is_420) begin
            if (slot < 3'(SLOTS_420_LEN)) c = SLOTS_420[slot];
        end else begin
            if (slot < 3'(SLOTS_444_LEN)) c = SLOTS_444[slot[1:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/jpeg_sched_oreg.sv
// One-entry output register slice towards the DCT input. Loads a beat
// with its side-band tags and holds it until downstream accepts.
module jpeg_sched_oreg
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_comp,
    input  logic          in_qsel,
    input  logic          in_first,
    input  logic          in_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_comp,
    output logic          out_qsel,
    output logic          out_first,
    output logic          out_last
);

    // Register slice: clear has priority, then load, then drain on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_comp  <= COMP_Y;
            out_qsel  <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_comp  <= COMP_Y;
            out_qsel  <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_comp  <= in_comp;
            out_qsel  <= in_qsel;
            out_first <= in_first;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// JPEG MCU scheduler: walks Y/Cb/Cr block buffers in 4:4:4 or 4:2:0 MCU
// order into the shared DCT pipeline, 64 beats per block, with restart
// marker handshakes every rst_interval MCUs.
// Optional macro JPEG_SCHED_PERF_EN adds perf_stall / perf_starve counters.
module jpeg_mcu_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned DW    = 12,
    parameter int unsigned MCU_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             subsamp_420,
    input  logic [MCU_W-1:0] mcu_total,
    input  logic [MCU_W-1:0] rst_interval,
    input  logic [2:0]       src_valid,
    input  logic [3*DW-1:0]  src_data,
    output logic [2:0]       src_ready,
    output logic [2:0]       block_done,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic [DW-1:0]    dct_data,
    output logic [1:0]       dct_comp,
    output logic             dct_qsel,
    output logic             dct_first,
    output logic             dct_last,
    output logic             rst_marker_req,
    input  logic             rst_marker_ack,
    output logic [2:0]       rst_idx,
    output logic             busy,
    output logic             done
`ifdef JPEG_SCHED_PERF_EN
   ,output logic [31:0]      perf_stall,
    output logic [31:0]      perf_starve
`endif
);

    sched_state_t     state, state_nxt;

    logic             cfg_420;
    logic [MCU_W-1:0] cfg_total;
    logic [MCU_W-1:0] cfg_interval;
    logic [2:0]       slot;
    logic [5:0]       beat_cnt;
    logic [MCU_W-1:0] mcu_cnt;
    logic [MCU_W-1:0] int_cnt;
    logic [1:0]       sel;

    logic [2:0]       sel_mask;
    logic [DW-1:0]    sel_data;
    logic             slice_free;
    logic             accept;
    logic             block_end;
    logic             final_slot;
    logic [MCU_W-1:0] mcu_nxt;
    logic [MCU_W-1:0] int_nxt;
    logic             mcu_last;
    logic             interval_hit;
    logic             start_acc;

    // Handshake, slot and counter decode for the current cycle.
    always_comb begin
        sel_mask     = 3'b001 << sel;
        slice_free   = !dct_valid || dct_ready;
        src_ready    = (state == STREAM && slice_free) ? sel_mask : 3'b000;
        accept       = |(src_valid & src_ready);
        block_end    = accept && (beat_cnt == 6'(BEATS_PER_BLOCK - 1));
        final_slot   = cfg_420 ? (slot == 3'(SLOTS_420_LEN - 1))
                               : (slot == 3'(SLOTS_444_LEN - 1));
        mcu_nxt      = mcu_cnt + MCU_W'(1);
        int_nxt      = int_cnt + MCU_W'(1);
        mcu_last     = (mcu_nxt == cfg_total);
        interval_hit = (cfg_interval != '0) && (int_nxt == cfg_interval);
        start_acc    = (state == IDLE) && start && !abort;
        sel_data     = src_data[DW-1:0];
        case (sel)
            COMP_CB: sel_data = src_data[2*DW-1:DW];
            COMP_CR: sel_data = src_data[3*DW-1:2*DW];
            default: sel_data = src_data[DW-1:0];
        endcase
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (mcu_total == '0) ? DONE : SELECT;
            SELECT:  state_nxt = STREAM;
            STREAM: begin
                if (block_end) begin
                    if (!final_slot)       state_nxt = SELECT;
                    else if (mcu_last)     state_nxt = DONE;
                    else if (interval_hit) state_nxt = RESTART;
                    else                   state_nxt = SELECT;
                end
            end
            RESTART: if (rst_marker_req && rst_marker_ack) state_nxt = SELECT;
            DONE:    if (!dct_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Configuration, slot/beat/MCU counters, marker handshake and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_420        <= 1'b0;
            cfg_total      <= '0;
            cfg_interval   <= '0;
            slot           <= '0;
            beat_cnt       <= '0;
            mcu_cnt        <= '0;
            int_cnt        <= '0;
            sel            <= COMP_Y;
            block_done     <= '0;
            rst_marker_req <= 1'b0;
            rst_idx        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            block_done <= '0;
            done       <= 1'b0;
            if (abort) begin
                busy           <= 1'b0;
                rst_marker_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_acc) begin
                            cfg_420      <= subsamp_420;
                            cfg_total    <= mcu_total;
                            cfg_interval <= rst_interval;
                            slot         <= '0;
                            beat_cnt     <= '0;
                            mcu_cnt      <= '0;
                            int_cnt      <= '0;
                            busy         <= 1'b1;
                        end
                    end
                    SELECT: sel <= slot_comp(cfg_420, slot);
                    STREAM: begin
                        if (accept) beat_cnt <= beat_cnt + 6'd1;
                        if (block_end) begin
                            block_done <= sel_mask;
                            if (final_slot) begin
                                slot    <= '0;
                                mcu_cnt <= mcu_nxt;
                                int_cnt <= interval_hit ? '0 : int_nxt;
                            end else begin
                                slot <= slot + 3'd1;
                            end
                        end
                    end
                    RESTART: begin
                        // Request only once the slice has drained; ack is
                        // only honoured while the request is up.
                        if (!rst_marker_req && !dct_valid) begin
                            rst_marker_req <= 1'b1;
                        end else if (rst_marker_req && rst_marker_ack) begin
                            rst_marker_req <= 1'b0;
                            rst_idx        <= rst_idx + 3'd1;
                        end
                    end
                    DONE: begin
                        if (!dct_valid) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    jpeg_sched_oreg #(
        .DW(DW)
    ) u_oreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort),
        .load      (accept),
        .in_data   (sel_data),
        .in_comp   (sel),
        .in_qsel   (sel != COMP_Y),
        .in_first  (beat_cnt == '0),
        .in_last   (beat_cnt == 6'(BEATS_PER_BLOCK - 1)),
        .out_ready (dct_ready),
        .out_valid (dct_valid),
        .out_data  (dct_data),
        .out_comp  (dct_comp),
        .out_qsel  (dct_qsel),
        .out_first (dct_first),
        .out_last  (dct_last)
    );

`ifdef JPEG_SCHED_PERF_EN
    // Saturating stall/starve counters, cleared when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall  <= '0;
            perf_starve <= '0;
        end else if (start_acc) begin
            perf_stall  <= '0;
            perf_starve <= '0;
        end else begin
            if (dct_valid && !dct_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (state == STREAM && !(|(src_valid & sel_mask)) && perf_starve != '1)
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Scoreboard bench for jpeg_mcu_scheduler: expected beats are queued from
// the slot table when a frame is issued; a monitor pops on each transfer.
module tb_jpeg_mcu_scheduler;

    localparam int DW    = 12;
    localparam int MCU_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             subsamp_420;
    logic [MCU_W-1:0] mcu_total;
    logic [MCU_W-1:0] rst_interval;
    logic [2:0]       src_valid;
    logic [3*DW-1:0]  src_data;
    logic [2:0]       src_ready;
    logic [2:0]       block_done;
    logic             dct_valid;
    logic             dct_ready;
    logic [DW-1:0]    dct_data;
    logic [1:0]       dct_comp;
    logic             dct_qsel;
    logic             dct_first;
    logic             dct_last;
    logic             rst_marker_req;
    logic             rst_marker_ack;
    logic [2:0]       rst_idx;
    logic             busy;
    logic             done;
`ifdef JPEG_SCHED_PERF_EN
    logic [31:0]      perf_stall;
    logic [31:0]      perf_starve;
`endif

    jpeg_mcu_scheduler #(
        .DW(DW),
        .MCU_W(MCU_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .subsamp_420    (subsamp_420),
        .mcu_total      (mcu_total),
        .rst_interval   (rst_interval),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .block_done     (block_done),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_data       (dct_data),
        .dct_comp       (dct_comp),
        .dct_qsel       (dct_qsel),
        .dct_first      (dct_first),
        .dct_last       (dct_last),
        .rst_marker_req (rst_marker_req),
        .rst_marker_ack (rst_marker_ack),
        .rst_idx        (rst_idx),
        .busy           (busy),
        .done           (done)
`ifdef JPEG_SCHED_PERF_EN
       ,.perf_stall     (perf_stall),
        .perf_starve    (perf_starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    comp;
        logic          qsel;
        logic          first;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ptr[3];
    logic        src_en   = 1'b0;
    logic        rand_src = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        force_ack = 1'b0;
    int unsigned beats_seen = 0;
    int unsigned bd_cnt     = 0;
    int unsigned done_cnt   = 0;
    int unsigned stall_cnt  = 0;
    int unsigned req_rise   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fdat(input int c, input int unsigned n);
        logic [1:0] cc;
        logic [9:0] nn;
        cc = 2'(c);
        nn = 10'(n);
        return {cc, nn};
    endfunction

    // Expected beat stream of a frame, from the MCU slot order.
    task automatic gen_frame(input logic is420, input int unsigned total);
        int unsigned cnt[3];
        int unsigned nslots;
        int c;
        beat_t b;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        nslots = is420 ? 6 : 3;
        for (int unsigned m = 0; m < total; m++) begin
            for (int unsigned s = 0; s < nslots; s++) begin
                if (is420) c = (s < 4) ? 0 : int'(s) - 3;
                else       c = int'(s);
                for (int unsigned k = 0; k < 64; k++) begin
                    b.data  = fdat(c, cnt[c]);
                    b.comp  = 2'(c);
                    b.qsel  = (c != 0);
                    b.first = (k == 0);
                    b.last  = (k == 63);
                    exp_q.push_back(b);
                    cnt[c]++;
                end
            end
        end
    endtask

    task automatic start_frame(input logic is420, input int unsigned total, input int unsigned intv);
        src_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ptr[0] = 0; ptr[1] = 0; ptr[2] = 0;
        gen_frame(is420, total);
        subsamp_420  = is420;
        mcu_total    = MCU_W'(total);
        rst_interval = MCU_W'(intv);
        src_en       = 1'b1;
        stall_cnt    = 0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned d0;
        int unsigned k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (4) @(negedge clk);
        check({name, "_done_once"}, done_cnt - d0, 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // Source model: each component presents its next sample; advances on handshake.
    initial begin
        logic [2:0] hs;
        src_valid = '0;
        src_data  = '0;
        dct_ready = 1'b1;
        ptr[0] = 0; ptr[1] = 0; ptr[2] = 0;
        forever begin
            @(negedge clk);
            hs = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (hs[c]) ptr[c]++;
                src_valid[c] = src_en && (!rand_src || ($urandom_range(3) != 0));
                src_data[c*DW +: DW] = fdat(c, ptr[c]);
            end
            dct_ready = !rand_rdy || ($urandom_range(1) == 1);
        end
    end

    // Marker writer: acknowledges a request after it has been up for 5 cycles.
    initial begin
        int unsigned age;
        age = 0;
        rst_marker_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_marker_req && !rst_marker_ack) age++;
            else age = 0;
            @(posedge clk);
            #1;
            rst_marker_ack = (age == 5) || force_ack;
        end
    end

    // Monitor: scoreboard pop on transfer, stall stability, pulse and marker tracking.
    initial begin
        beat_t       cur;
        beat_t       held;
        beat_t       e;
        logic        prev_stall;
        logic        prev_req;
        int unsigned req_len;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        req_len    = 0;
        held       = '0;
        forever begin
            @(negedge clk);
            cur = {dct_data, dct_comp, dct_qsel, dct_first, dct_last};
            if (prev_stall)
                check("stall_stable", {dct_valid, cur}, {1'b1, held});
            if (dct_valid && dct_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got 0x%0h with no expected beat at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(cur), 32'(e));
                end
                beats_seen++;
            end
            prev_stall = dct_valid && !dct_ready;
            held       = cur;
            if (prev_stall) stall_cnt++;
            bd_cnt   += $countones(block_done);
            done_cnt += 32'(done);
            if (rst_marker_req) begin
                if (!prev_req) begin
                    req_rise++;
                    check("rst_idx_at_req", 32'(rst_idx), req_rise - 1);
                end
                req_len++;
                check("req_after_drain", 32'(dct_valid), 32'd0);
            end else if (prev_req) begin
                check("req_hold_len", req_len, 32'd6);
                req_len = 0;
            end
            prev_req = rst_marker_req;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0;
        int unsigned bd0;
        int unsigned d0;
        int unsigned k;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        subsamp_420  = 1'b0;
        mcu_total    = '0;
        rst_interval = '0;

        #12;
        check("reset_outputs",
              {dct_valid, dct_data, dct_comp, dct_qsel, dct_first, dct_last, src_ready,
               block_done, busy, done, rst_marker_req, rst_idx}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 4:4:4, two MCUs, no restarts.
        b0 = beats_seen; bd0 = bd_cnt;
        start_frame(1'b0, 2, 0);
        wait_done("t444", 3000);
        check("t444_beats", beats_seen - b0, 32'd384);
        check("t444_block_done", bd_cnt - bd0, 32'd6);

        // 4:2:0, one MCU.
        b0 = beats_seen; bd0 = bd_cnt;
        start_frame(1'b1, 1, 0);
        wait_done("t420", 3000);
        check("t420_beats", beats_seen - b0, 32'd384);
        check("t420_block_done", bd_cnt - bd0, 32'd6);

        // Ack with no request outstanding has no effect.
        @(posedge clk); #1;
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ack_idx", 32'(rst_idx), 32'd0);
        check("idle_ack_req", 32'(rst_marker_req), 32'd0);

        // 4:4:4, three MCUs, restart every MCU: markers after MCU0 and MCU1 only.
        b0 = beats_seen; req_rise = 0;
        start_frame(1'b0, 3, 1);
        wait_done("trst", 5000);
        check("trst_beats", beats_seen - b0, 32'd576);
        check("trst_req_count", req_rise, 32'd2);
        check("trst_idx_final", 32'(rst_idx), 32'd2);

        // Random backpressure and source gaps.
        rand_src = 1'b1;
        rand_rdy = 1'b1;
        b0 = beats_seen;
        start_frame(1'b1, 2, 0);
        wait_done("trand", 12000);
        check("trand_beats", beats_seen - b0, 32'd768);
`ifdef JPEG_SCHED_PERF_EN
        check("trand_perf_stall", perf_stall, stall_cnt);
`endif
        rand_src = 1'b0;
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Abort during the Cb block of the first MCU.
        b0 = beats_seen; bd0 = bd_cnt;
        start_frame(1'b0, 2, 0);
        k = 0;
        while (beats_seen - b0 < 94 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_cb", 32'(beats_seen - b0 >= 94), 32'd1);
        d0 = done_cnt;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_outputs", {dct_valid, busy, src_ready}, 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_block_done", bd_cnt - bd0, 32'd1);
        src_en = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        b0 = beats_seen;
        start_frame(1'b0, 1, 0);
        wait_done("tpost_abort", 3000);
        check("tpost_abort_beats", beats_seen - b0, 32'd192);

        // Empty frame: done within two cycles, no beats.
        b0 = beats_seen; d0 = done_cnt;
        start_frame(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        check("empty_done", done_cnt - d0, 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_beats", beats_seen - b0, 32'd0);

        // Asynchronous reset in the middle of a block.
        b0 = beats_seen;
        start_frame(1'b0, 1, 0);
        k = 0;
        while (beats_seen - b0 < 20 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("arst_streaming", 32'(dct_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_outputs",
              {dct_valid, dct_data, dct_comp, dct_qsel, dct_first, dct_last, src_ready,
               block_done, busy, done, rst_marker_req, rst_idx}, 32'd0);
        src_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
